// File: rtl/wb_pkg.sv
// rtl/wb_pkg.sv - shared encodings and widths for the Wishbone initiator
package wb_pkg;

    localparam int WB_DATA_W = 64;

    // Slave register select carried on wb_adr_o
    localparam logic WB_ADR_COMMAND = 1'b0;
    localparam logic WB_ADR_DATA    = 1'b1;

    typedef enum logic [1:0] {
        WB_M_IDLE   = 2'd0,
        WB_M_STROBE = 2'd1,
        WB_M_DONE   = 2'd2
    } wb_m_state_e;

endpackage

// File: rtl/wb_timeout_counter.sv
// rtl/wb_timeout_counter.sv - counts unacknowledged strobe cycles and flags expiry
module wb_timeout_counter #(
    parameter int LIMIT = 16,
    parameter int CNT_W = $clog2(LIMIT) + 1
) (
    input  logic clock,
    input  logic reset,
    input  logic clear,
    input  logic enable,
    output logic expired
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] count;

    // Count waited strobe cycles; cleared whenever no strobe is pending
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + CNT_W'(1);
        end
    end

    // Expiry is seen during the last allowed strobe cycle, so the strobe
    // stays high for exactly LIMIT cycles before the abort
    assign expired = (count == LAST);

endmodule

// File: rtl/wishbone_master.sv
// rtl/wishbone_master.sv - single-transfer Wishbone initiator with ack timeout
module wishbone_master
    import wb_pkg::*;
#(
    parameter int DATA_W         = WB_DATA_W,
    parameter int TIMEOUT_CYCLES = 16,
    parameter int TO_W           = $clog2(TIMEOUT_CYCLES) + 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_we,
    input  logic              req_adr,
    input  logic [DATA_W-1:0] req_data,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic              rsp_err,
    output logic              wb_cyc_o,
    output logic              wb_stb_o,
    output logic              wb_we_o,
    output logic              wb_adr_o,
    output logic [DATA_W-1:0] wb_data_o,
    input  logic [DATA_W-1:0] wb_data_i,
    input  logic              wb_ack_i
);

    wb_m_state_e       state, state_n;
    logic              ready_n;
    logic              stb_n;
    logic              we_n;
    logic              adr_n;
    logic [DATA_W-1:0] wdata_n;
    logic              rsp_valid_n;
    logic [DATA_W-1:0] rsp_data_n;
    logic              rsp_err_n;
    logic              expired;
    logic              to_clear;
    logic              to_enable;

    assign to_clear  = (state != WB_M_STROBE);
    assign to_enable = (state == WB_M_STROBE) && !wb_ack_i;

    wb_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (TO_W)
    ) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clear   (to_clear),
        .enable  (to_enable),
        .expired (expired)
    );

    // Cycle and strobe always travel together on this bus
    assign wb_cyc_o = wb_stb_o;

    // Next-state and next-output decode; the bus registers double as the request latch
    always_comb begin
        state_n     = state;
        ready_n     = req_ready;
        stb_n       = wb_stb_o;
        we_n        = wb_we_o;
        adr_n       = wb_adr_o;
        wdata_n     = wb_data_o;
        rsp_valid_n = 1'b0;
        rsp_data_n  = rsp_data;
        rsp_err_n   = rsp_err;
        case (state)
            WB_M_IDLE: begin
                ready_n = 1'b1;
                if (req_valid) begin
                    state_n = WB_M_STROBE;
                    ready_n = 1'b0;
                    stb_n   = 1'b1;
                    we_n    = req_we;
                    adr_n   = req_adr;
                    wdata_n = req_we ? req_data : '0;
                end
            end
            WB_M_STROBE: begin
                ready_n = 1'b0;
                // An ack on the expiry cycle is a normal completion
                if (wb_ack_i || expired) begin
                    state_n     = WB_M_DONE;
                    stb_n       = 1'b0;
                    we_n        = 1'b0;
                    adr_n       = WB_ADR_COMMAND;
                    wdata_n     = '0;
                    rsp_valid_n = 1'b1;
                    rsp_err_n   = !wb_ack_i;
                    rsp_data_n  = (wb_ack_i && !wb_we_o) ? wb_data_i : '0;
                end
            end
            WB_M_DONE: begin
                state_n = WB_M_IDLE;
                ready_n = 1'b1;
            end
            default: begin
                state_n    = WB_M_IDLE;
                ready_n    = 1'b1;
                stb_n      = 1'b0;
                we_n       = 1'b0;
                adr_n      = WB_ADR_COMMAND;
                wdata_n    = '0;
                rsp_data_n = '0;
                rsp_err_n  = 1'b0;
            end
        endcase
    end

    // Register state and every output so the bus sees glitch-free signals
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state     <= WB_M_IDLE;
            req_ready <= 1'b1;
            wb_stb_o  <= 1'b0;
            wb_we_o   <= 1'b0;
            wb_adr_o  <= WB_ADR_COMMAND;
            wb_data_o <= '0;
            rsp_valid <= 1'b0;
            rsp_data  <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_n;
            req_ready <= ready_n;
            wb_stb_o  <= stb_n;
            wb_we_o   <= we_n;
            wb_adr_o  <= adr_n;
            wb_data_o <= wdata_n;
            rsp_valid <= rsp_valid_n;
            rsp_data  <= rsp_data_n;
            rsp_err   <= rsp_err_n;
        end
    end

endmodule

// File: tb/tb_wishbone_master.sv
// tb/tb_wishbone_master.sv - randomized self-checking bench with transaction-level model
module tb_wishbone_master;
    import wb_pkg::*;

    localparam int DW = 64;
    localparam int TO = 16;

    logic          clock = 1'b0;
    logic          reset = 1'b0;
    logic          req_valid = 1'b0;
    logic          req_ready;
    logic          req_we = 1'b0;
    logic          req_adr = 1'b0;
    logic [DW-1:0] req_data = '0;
    logic          rsp_valid;
    logic [DW-1:0] rsp_data;
    logic          rsp_err;
    logic          wb_cyc_o;
    logic          wb_stb_o;
    logic          wb_we_o;
    logic          wb_adr_o;
    logic [DW-1:0] wb_data_o;
    logic [DW-1:0] wb_data_i = '0;
    logic          wb_ack_i = 1'b0;

    always #5 clock = ~clock;

    wishbone_master #(
        .DATA_W         (DW),
        .TIMEOUT_CYCLES (TO)
    ) dut (
        .clock     (clock),
        .reset     (reset),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_we    (req_we),
        .req_adr   (req_adr),
        .req_data  (req_data),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .wb_cyc_o  (wb_cyc_o),
        .wb_stb_o  (wb_stb_o),
        .wb_we_o   (wb_we_o),
        .wb_adr_o  (wb_adr_o),
        .wb_data_o (wb_data_o),
        .wb_data_i (wb_data_i),
        .wb_ack_i  (wb_ack_i)
    );

    // Transaction-level model: a transfer in flight, strobe cycles elapsed, one response cycle
    logic          m_ready, m_stb, m_we, m_adr, m_rsp_valid, m_rsp_err;
    logic [DW-1:0] m_wdata, m_rsp_data;
    logic          m_busy, m_done, m_twe;
    int            m_elapsed;

    always @(posedge clock or negedge reset) begin
        if (!reset) begin
            m_ready <= 1'b1; m_stb <= 1'b0; m_we <= 1'b0; m_adr <= 1'b0;
            m_wdata <= '0; m_rsp_valid <= 1'b0; m_rsp_data <= '0; m_rsp_err <= 1'b0;
            m_busy <= 1'b0; m_done <= 1'b0; m_twe <= 1'b0; m_elapsed <= 0;
        end else begin
            m_rsp_valid <= 1'b0;
            if (m_done) begin
                m_done  <= 1'b0;
                m_ready <= 1'b1;
            end else if (m_busy) begin
                m_elapsed <= m_elapsed + 1;
                if (wb_ack_i || (m_elapsed + 1 == TO)) begin
                    m_rsp_valid <= 1'b1;
                    m_rsp_err   <= !wb_ack_i;
                    m_rsp_data  <= (wb_ack_i && !m_twe) ? wb_data_i : '0;
                    m_stb <= 1'b0; m_we <= 1'b0; m_adr <= 1'b0; m_wdata <= '0;
                    m_busy <= 1'b0;
                    m_done <= 1'b1;
                end
            end else if (req_valid) begin
                m_busy    <= 1'b1;
                m_elapsed <= 0;
                m_twe     <= req_we;
                m_stb     <= 1'b1;
                m_we      <= req_we;
                m_adr     <= req_adr;
                m_wdata   <= req_we ? req_data : '0;
                m_ready   <= 1'b0;
            end
        end
    end

    int            checks = 0;
    int            passed = 0;
    int            stb_total = 0;
    int            rsp_total = 0;
    int            low_run = 0;
    int            last_gap = -1;
    int            s_idx = 0;
    int            ack_delay = 99;
    bit            seen_stb = 1'b0;
    bit            prev_stb = 1'b0;
    bit            force_ack = 1'b0;
    bit            slave_rand = 1'b0;
    bit            noise = 1'b0;
    bit            rd_fixed_en = 1'b0;
    logic [DW-1:0] rd_fixed = '0;
    logic [DW-1:0] last_data = '0;
    logic [DW-1:0] last_wdata = '0;
    logic          last_err = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h required %0h", name, act, exp);
    endtask

    // One clock: compare at the falling edge, then drive the slave just after the rising edge
    task automatic tick();
        @(negedge clock);
        check("req_ready", 64'(req_ready), 64'(m_ready));
        check("wb_stb_o", 64'(wb_stb_o), 64'(m_stb));
        check("wb_cyc_o", 64'(wb_cyc_o), 64'(m_stb));
        check("wb_we_o", 64'(wb_we_o), 64'(m_we));
        check("wb_adr_o", 64'(wb_adr_o), 64'(m_adr));
        check("wb_data_o", wb_data_o, m_wdata);
        check("rsp_valid", 64'(rsp_valid), 64'(m_rsp_valid));
        check("rsp_err", 64'(rsp_err), 64'(m_rsp_err));
        check("rsp_data", rsp_data, m_rsp_data);
        if (wb_stb_o) begin
            stb_total++;
            last_wdata = wb_data_o;
            if (!prev_stb && seen_stb) last_gap = low_run;
            seen_stb = 1'b1;
            low_run = 0;
        end else begin
            low_run++;
        end
        prev_stb = wb_stb_o;
        if (rsp_valid) begin
            rsp_total++;
            last_data = rsp_data;
            last_err  = rsp_err;
        end
        @(posedge clock);
        #2;
        if (wb_stb_o) s_idx++;
        else s_idx = 0;
        wb_ack_i = force_ack
                 || (wb_stb_o && (slave_rand ? ($urandom_range(3) == 0) : (s_idx == ack_delay)))
                 || (noise && ($urandom_range(2) == 0));
        wb_data_i = rd_fixed_en ? rd_fixed : {$urandom(), $urandom()};
    endtask

    task automatic issue(input logic we, input logic adr, input logic [DW-1:0] data, input bit keep);
        int n;
        req_valid = 1'b1;
        req_we    = we;
        req_adr   = adr;
        req_data  = data;
        n = 0;
        while (!req_ready && n < 64) begin
            tick();
            n++;
        end
        if (n >= 64) check("accept_bound", 64'(0), 64'(1));
        tick();
        if (!keep) req_valid = 1'b0;
    endtask

    task automatic wait_rsp(input int target);
        int n;
        n = 0;
        while (rsp_total < target && n < 64) begin
            tick();
            n++;
        end
        if (rsp_total < target) check("rsp_bound", 64'(rsp_total), 64'(target));
    endtask

    initial begin
        int  s0, r0;
        bit  acc;

        repeat (3) tick();
        check("reset_req_ready", 64'(req_ready), 64'(1));
        check("reset_stb", 64'(wb_stb_o), 64'(0));
        check("reset_rsp_valid", 64'(rsp_valid), 64'(0));
        check("reset_rsp_data", rsp_data, 64'h0);
        reset = 1'b1;
        repeat (2) tick();

        // Write command, ack in the third strobe cycle
        ack_delay = 3;
        s0 = stb_total; r0 = rsp_total;
        issue(1'b1, WB_ADR_COMMAND, 64'hA5A5_0000_0000_0001, 1'b0);
        wait_rsp(r0 + 1);
        repeat (2) tick();
        check("wr_stb_cycles", 64'(stb_total - s0), 64'(3));
        check("wr_rsp_count", 64'(rsp_total - r0), 64'(1));
        check("wr_wdata", last_wdata, 64'hA5A5_0000_0000_0001);
        check("wr_err", 64'(last_err), 64'(0));
        check("wr_rsp_data", last_data, 64'h0);

        // Read from data register
        ack_delay = 2; rd_fixed_en = 1'b1; rd_fixed = 64'hDEAD_BEEF_CAFE_F00D;
        r0 = rsp_total;
        issue(1'b0, WB_ADR_DATA, {$urandom(), $urandom()}, 1'b0);
        wait_rsp(r0 + 1);
        repeat (2) tick();
        check("rd_data", last_data, 64'hDEAD_BEEF_CAFE_F00D);
        check("rd_err", 64'(last_err), 64'(0));

        // No ack at all: abort after the full strobe window
        ack_delay = 99;
        s0 = stb_total; r0 = rsp_total;
        issue(1'b0, WB_ADR_DATA, 64'h0, 1'b0);
        wait_rsp(r0 + 1);
        repeat (2) tick();
        check("to_stb_cycles", 64'(stb_total - s0), 64'(16));
        check("to_err", 64'(last_err), 64'(1));
        check("to_rsp_data", last_data, 64'h0);

        // Ack in the final allowed strobe cycle completes normally
        ack_delay = 16; rd_fixed = 64'h0123_4567_89AB_CDEF;
        s0 = stb_total; r0 = rsp_total;
        issue(1'b0, WB_ADR_DATA, 64'h0, 1'b0);
        wait_rsp(r0 + 1);
        repeat (2) tick();
        check("late_stb_cycles", 64'(stb_total - s0), 64'(16));
        check("late_err", 64'(last_err), 64'(0));
        check("late_data", last_data, 64'h0123_4567_89AB_CDEF);

        // Back-to-back with req_valid held high across both requests
        ack_delay = 1; rd_fixed = 64'h5555_AAAA_0F0F_F0F0;
        s0 = stb_total; r0 = rsp_total;
        issue(1'b1, WB_ADR_DATA, 64'h1111_2222_3333_4444, 1'b1);
        issue(1'b0, WB_ADR_COMMAND, 64'h0, 1'b0);
        wait_rsp(r0 + 2);
        repeat (2) tick();
        check("b2b_rsp_count", 64'(rsp_total - r0), 64'(2));
        check("b2b_stb_cycles", 64'(stb_total - s0), 64'(2));
        check("b2b_gap", 64'(last_gap), 64'(2));
        check("b2b_last_data", last_data, 64'h5555_AAAA_0F0F_F0F0);

        // Reset asserted mid-strobe, then an ack that must be ignored
        ack_delay = 99; rd_fixed_en = 1'b0;
        r0 = rsp_total;
        issue(1'b1, WB_ADR_DATA, 64'hFEED_0000_0000_BEEF, 1'b0);
        repeat (3) tick();
        #1 reset = 1'b0;
        #1;
        check("rst_stb", 64'(wb_stb_o), 64'(0));
        check("rst_cyc", 64'(wb_cyc_o), 64'(0));
        check("rst_rsp_valid", 64'(rsp_valid), 64'(0));
        check("rst_req_ready", 64'(req_ready), 64'(1));
        force_ack = 1'b1;
        tick();
        reset = 1'b1;
        s0 = stb_total;
        repeat (3) tick();
        force_ack = 1'b0;
        repeat (2) tick();
        check("rst_no_rsp", 64'(rsp_total - r0), 64'(0));
        check("rst_no_stb", 64'(stb_total - s0), 64'(0));

        // Randomized traffic with varying slave behaviour
        for (int i = 0; i < 600; i++) begin
            if (i % 50 == 0) begin
                case ($urandom_range(2))
                    0: begin slave_rand = 1'b1; noise = 1'($urandom_range(1)); end
                    1: begin slave_rand = 1'b0; noise = 1'b0; ack_delay = $urandom_range(16, 1); end
                    default: begin slave_rand = 1'b0; noise = 1'b0; ack_delay = 99; end
                endcase
            end
            acc = req_valid && req_ready;
            tick();
            if (!req_valid || acc) begin
                req_valid = 1'($urandom_range(1));
                req_we    = 1'($urandom_range(1));
                req_adr   = 1'($urandom_range(1));
                req_data  = {$urandom(), $urandom()};
            end
        end
        req_valid = 1'b0;
        slave_rand = 1'b0; noise = 1'b0; ack_delay = 1;
        repeat (24) tick();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
